dpram_sc_be: RTL



---
 rtl/dpram_sc_be_if.sv | 41 ++++
 rtl/dpram_sc_be.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dpram_sc_be_if.sv
// Port bundle for dpram_sc_be: two independent RAM ports plus clear control.
// The master side drives requests; the slave side is the RAM.
interface dpram_sc_be_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  localparam int NB = DATA_W / 8;

  logic              clr;
  logic              busy;

  logic              cea;
  logic              wrea;
  logic [NB-1:0]     bea;
  logic [ADDR_W-1:0] ada;
  logic [DATA_W-1:0] dina;
  logic              ocea;
  logic [DATA_W-1:0] douta;

  logic              ceb;
  logic              wreb;
  logic [NB-1:0]     beb;
  logic [ADDR_W-1:0] adb;
  logic [DATA_W-1:0] dinb;
  logic              oceb;
  logic [DATA_W-1:0] doutb;

  logic              collision;

  modport master (
    output clr, cea, wrea, bea, ada, dina, ocea,
    output ceb, wreb, beb, adb, dinb, oceb,
    input  busy, douta, doutb, collision
  );

  modport slave (
    input  clr, cea, wrea, bea, ada, dina, ocea,
    input  ceb, wreb, beb, adb, dinb, oceb,
    output busy, douta, doutb, collision
  );
endinterface

// File: rtl/dpram_sc_be.sv
// Single-clock true dual-port RAM with byte enables, selectable write mode,
// optional output register, deterministic collision merge and a clear sequencer.
module dpram_sc_be #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int OUT_REG        = 1,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  dpram_sc_be_if.slave  bus
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DONE
  } clr_state_e;

  localparam clr_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              busy;
  logic              clearing;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.clr) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end
      end
      S_CLEAR: begin
        // Explicit terminal count: the counter is parked at 0, never wrapped.
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = S_DONE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign clearing = (state_q == S_CLEAR);
  assign bus.busy = busy;

  // ---------------------------------------------------------------------------
  // Access qualification and collision merge
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc_a, acc_b;
  logic              wr_a, wr_b;
  logic              same_addr, both_wr, coll_d;
  logic [DATA_W-1:0] old_a, old_b;
  logic [DATA_W-1:0] merged_a, merged_b;
  logic [DATA_W-1:0] rd_a_d, rd_b_d;

  assign acc_a     = !busy && bus.cea;
  assign acc_b     = !busy && bus.ceb;
  assign wr_a      = acc_a && bus.wrea;
  assign wr_b      = acc_b && bus.wreb;
  assign same_addr = acc_a && acc_b && (bus.ada == bus.adb);
  assign both_wr   = same_addr && wr_a && wr_b;
  assign coll_d    = same_addr && (wr_a || wr_b);

  assign old_a = mem[bus.ada];
  assign old_b = mem[bus.adb];

  // Both ports compute the same final word on a double write (A has byte
  // priority), so the two array writes below never disagree.
  always_comb begin
    merged_a = old_a;
    merged_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (wr_a && bus.bea[i])
        merged_a[8*i +: 8] = bus.dina[8*i +: 8];
      else if (both_wr && bus.beb[i])
        merged_a[8*i +: 8] = bus.dinb[8*i +: 8];

      if (both_wr && bus.bea[i])
        merged_b[8*i +: 8] = bus.dina[8*i +: 8];
      else if (wr_b && bus.beb[i])
        merged_b[8*i +: 8] = bus.dinb[8*i +: 8];
    end
  end

  // A reading port always sees the pre-write word, even when the other
  // port writes the same address this cycle.
  assign rd_a_d = (wr_a && (WRITE_MODE == 0)) ? merged_a : old_a;
  assign rd_b_d = (wr_b && (WRITE_MODE == 0)) ? merged_b : old_b;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset on purpose; a reset branch here would turn
  // RAM into flops. Zeroing is the clear sequencer's job.
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clr_addr_q] <= '0;
    end else begin
      if (wr_a) mem[bus.ada] <= merged_a;
      if (wr_b) mem[bus.adb] <= merged_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline and collision flag
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rd_a_q, rd_b_q;
  logic [DATA_W-1:0] out_a_q, out_b_q;
  logic              coll_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      out_a_q <= '0;
      out_b_q <= '0;
      coll_q  <= 1'b0;
    end else begin
      if (acc_a) rd_a_q <= rd_a_d;
      if (acc_b) rd_b_q <= rd_b_d;
      // Output stage is frozen while busy so dout holds during a clear.
      if ((OUT_REG != 0) && !busy && bus.ocea) out_a_q <= rd_a_q;
      if ((OUT_REG != 0) && !busy && bus.oceb) out_b_q <= rd_b_q;
      coll_q <= coll_d;
    end
  end

  assign bus.douta     = (OUT_REG != 0) ? out_a_q : rd_a_q;
  assign bus.doutb     = (OUT_REG != 0) ? out_b_q : rd_b_q;
  assign bus.collision = coll_q;

endmodule
